// File: rtl/lz77_if.sv
// Token-in / byte-out handshake bundle for the LZ77 decoder.
// master = token source and byte sink side, slave = decoder side.
interface lz77_if #(
  parameter int DATA_W = 8,
  parameter int OFF_W  = 4,
  parameter int LEN_W  = 4
);
  logic              token_valid;
  logic              token_ready;
  logic [OFF_W-1:0]  token_offset;
  logic [LEN_W-1:0]  token_length;
  logic [DATA_W-1:0] token_char;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;

  modport master (
    output token_valid, token_offset, token_length, token_char, data_ready,
    input  token_ready, data_out, data_valid
  );

  modport slave (
    input  token_valid, token_offset, token_length, token_char, data_ready,
    output token_ready, data_out, data_valid
  );
endinterface

// File: rtl/lz77_decoder.sv
// LZ77 decoder: expands (offset, length, char) tokens into a byte stream
// using a circular history window. Copy bytes come out first, then the
// literal char. One byte per handshake; history writes land on the
// handshake edge so overlapping copies read back freshly written bytes.
module lz77_decoder #(
  parameter int DATA_W    = 8,
  parameter int WIN_DEPTH = 16,
  parameter int OFF_W     = 4,
  parameter int LEN_W     = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  lz77_if.slave            bus,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] out_count
);
  localparam int PTR_W = $clog2(WIN_DEPTH);
  localparam int HC_W  = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, COPY, LIT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] hist [WIN_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [HC_W-1:0]   hist_count;
  logic [LEN_W-1:0]  remaining;
  logic [DATA_W-1:0] char_q;
  logic [DATA_W-1:0] dout;
  logic              accept, beat, ref_ok;

  assign accept = bus.token_valid && (state == IDLE);
  // data_valid is high in every non-IDLE state, so a beat is just data_ready there
  assign beat   = (state != IDLE) && bus.data_ready;
  // offset must point inside what has actually been emitted so far
  assign ref_ok = (bus.token_length == '0) ||
                  ((bus.token_offset != '0) &&
                   (32'(bus.token_offset) <= 32'(hist_count)));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic; invalid references skip the copy and go straight to LIT
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)
              state_nxt = (bus.token_length != '0 && ref_ok) ? COPY : LIT;
      COPY: if (beat && remaining == LEN_W'(1)) state_nxt = LIT;
      LIT:  if (beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state; reset forces IDLE so data_valid drops at once
  always_comb begin
    bus.token_ready = (state == IDLE);
    bus.data_valid  = (state != IDLE);
    busy            = (state != IDLE);
    dout            = '0;
    case (state)
      COPY:    dout = hist[rd_ptr];
      LIT:     dout = char_q;
      default: dout = '0;
    endcase
    bus.data_out = dout;
  end

  // pointers, counters, latched literal and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      hist_count <= '0;
      remaining  <= '0;
      char_q     <= '0;
      err        <= 1'b0;
      out_count  <= '0;
    end else if (accept) begin
      char_q <= bus.token_char;
      if (bus.token_length != '0) begin
        if (ref_ok) begin
          rd_ptr    <= wr_ptr - PTR_W'(bus.token_offset);
          remaining <= bus.token_length;
        end else begin
          err <= 1'b1;
        end
      end
    end else if (beat) begin
      wr_ptr    <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_ptr + PTR_W'(1);
      out_count <= out_count + CNT_W'(1);
      if (hist_count != HC_W'(WIN_DEPTH)) hist_count <= hist_count + HC_W'(1);
      if (state == COPY) remaining <= remaining - LEN_W'(1);
    end
  end

  // history window write; contents need no reset since hist_count gates reads
  always_ff @(posedge clk) begin
    if (beat) hist[wr_ptr] <= dout;
  end
endmodule

// File: tb/tb_lz77_decoder.sv
// Directed bench for lz77_decoder: a vector table of tokens with expected
// byte streams, plus hand sequences for window wrap and reset mid-copy.
module tb_lz77_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy, err;
  logic [15:0] out_count;

  lz77_if #(.DATA_W(8), .OFF_W(4), .LEN_W(4)) bus ();

  lz77_decoder #(.DATA_W(8), .WIN_DEPTH(16), .OFF_W(4), .LEN_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err(err), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] got [$];

  typedef struct {
    bit              do_rst;
    logic [3:0]      off;
    logic [3:0]      len;
    logic [7:0]      ch;
    int              nbeats;
    logic [0:4][7:0] exp;
    bit              exp_err;
    int              exp_cnt;
    int              stall_beat;
    int              stall_n;
  } vec_t;

  vec_t v [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.token_valid = 1'b0;
    bus.data_ready  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, bus.data_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_count", {16'b0, out_count}, 0);
    chk("rst_ready", {31'b0, bus.token_ready}, 1);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Present one token, then collect nbeats output bytes into got[].
  // stall_n cycles of data_ready=0 are inserted once beat stall_beat is reached.
  task automatic send(input logic [3:0] off, input logic [3:0] len, input logic [7:0] ch,
                      input int nbeats, input int stall_beat, input int stall_n);
    int beats, budget, stalls;
    logic [7:0] held;
    beats = 0; budget = 0; stalls = 0; held = '0;
    got.delete();
    bus.token_offset = off;
    bus.token_length = len;
    bus.token_char   = ch;
    bus.token_valid  = 1'b1;
    while (!bus.token_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) chk("accept_timeout", 1, 0);
    @(posedge clk);
    #1 bus.token_valid = 1'b0;
    @(negedge clk);
    chk("first_valid", {31'b0, bus.data_valid}, 1);
    budget = 0;
    while (beats < nbeats && budget < 100) begin
      if (beats == stall_beat && stalls < stall_n) begin
        bus.data_ready = 1'b0;
        if (stalls == 0) held = bus.data_out;
        else             chk("stall_hold", {24'b0, bus.data_out}, {24'b0, held});
        chk("stall_valid", {31'b0, bus.data_valid}, 1);
        stalls++;
      end else begin
        bus.data_ready = 1'b1;
      end
      if (bus.data_valid && bus.data_ready) begin
        got.push_back(bus.data_out);
        beats++;
      end
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) chk("beat_timeout", 1, 0);
    bus.data_ready = 1'b1;
  endtask

  initial begin
    bus.token_valid  = 1'b0;
    bus.token_offset = '0;
    bus.token_length = '0;
    bus.token_char   = '0;
    bus.data_ready   = 1'b1;

    //      rst   off   len   ch    nb  expected bytes                     err cnt sb sn
    v[0] = '{1'b1, 4'd0, 4'd0, "A", 1, {"A", 8'h0, 8'h0, 8'h0, 8'h0}, 1'b0, 1, 0, 0};
    v[1] = '{1'b0, 4'd0, 4'd0, "B", 1, {"B", 8'h0, 8'h0, 8'h0, 8'h0}, 1'b0, 2, 0, 0};
    v[2] = '{1'b0, 4'd0, 4'd0, "C", 1, {"C", 8'h0, 8'h0, 8'h0, 8'h0}, 1'b0, 3, 0, 0};
    v[3] = '{1'b0, 4'd3, 4'd3, "D", 4, {"A", "B", "C", "D", 8'h0},    1'b0, 7, 0, 0};
    v[4] = '{1'b1, 4'd0, 4'd0, "A", 1, {"A", 8'h0, 8'h0, 8'h0, 8'h0}, 1'b0, 1, 0, 0};
    v[5] = '{1'b0, 4'd1, 4'd4, "B", 5, {"A", "A", "A", "A", "B"},     1'b0, 6, 2, 3};
    v[6] = '{1'b1, 4'd2, 4'd3, "X", 1, {"X", 8'h0, 8'h0, 8'h0, 8'h0}, 1'b1, 1, 0, 0};
    v[7] = '{1'b0, 4'd0, 4'd0, "Y", 1, {"Y", 8'h0, 8'h0, 8'h0, 8'h0}, 1'b1, 2, 0, 0};

    for (int i = 0; i < 8; i++) begin
      if (v[i].do_rst) do_reset();
      send(v[i].off, v[i].len, v[i].ch, v[i].nbeats, v[i].stall_beat, v[i].stall_n);
      chk($sformatf("v%0d_nbytes", i), got.size(), v[i].nbeats);
      for (int b = 0; b < v[i].nbeats && b < got.size(); b++)
        chk($sformatf("v%0d_byte%0d", i, b), {24'b0, got[b]}, {24'b0, v[i].exp[b]});
      chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, v[i].exp_err});
      chk($sformatf("v%0d_count", i), {16'b0, out_count}, v[i].exp_cnt);
      chk($sformatf("v%0d_idle", i), {31'b0, busy}, 0);
    end

    // window wrap: 20 literals, then offset 15 reaches back past the wrap point
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send(4'd0, 4'd0, 8'(i), 1, 0, 0);
      chk($sformatf("wrap_lit%0d", i), {24'b0, (got.size() > 0) ? got[0] : 8'hxx}, i);
    end
    send(4'd15, 4'd2, "Z", 3, 0, 0);
    chk("wrap_nbytes", got.size(), 3);
    if (got.size() == 3) begin
      chk("wrap_b0", {24'b0, got[0]}, 32'h05);
      chk("wrap_b1", {24'b0, got[1]}, 32'h06);
      chk("wrap_b2", {24'b0, got[2]}, "Z");
    end
    chk("wrap_hist_count", 32'(dut.hist_count), 16);
    chk("wrap_count", {16'b0, out_count}, 23);
    chk("wrap_err", {31'b0, err}, 0);

    // reset during the second beat of a length-5 copy
    do_reset();
    send(4'd0, 4'd0, "A", 1, 0, 0);
    send(4'd0, 4'd0, "B", 1, 0, 0);
    bus.token_offset = 4'd2;
    bus.token_length = 4'd5;
    bus.token_char   = "C";
    bus.token_valid  = 1'b1;
    @(posedge clk);
    #1 bus.token_valid = 1'b0;
    @(negedge clk);
    chk("mid_beat1", {24'b0, bus.data_out}, "A");
    @(negedge clk);
    chk("mid_beat2", {24'b0, bus.data_out}, "B");
    chk("mid_busy_before", {31'b0, busy}, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, bus.data_valid}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_count", {16'b0, out_count}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(4'd1, 4'd1, "Q", 1, 0, 0);
    chk("mid_q_nbytes", got.size(), 1);
    if (got.size() > 0) chk("mid_q_byte", {24'b0, got[0]}, "Q");
    chk("mid_q_err", {31'b0, err}, 1);
    chk("mid_q_count", {16'b0, out_count}, 1);
    // one more cycle: nothing else must come out
    chk("mid_q_no_extra", {31'b0, bus.data_valid}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lz77_decoder.md
Name: lz77_decoder

Overview:
- Decompression side of the LZ77 datapath. It consumes (offset, length, next_char) tokens produced by the compressor and emits the reconstructed byte stream one byte per handshake.
- Keeps a circular history window of the most recently emitted bytes. Back-references are copied out of this window, then the literal next_char is appended.
- Sits between the token source (compressed stream) and the downstream byte sink (output buffer).

Parameters:
- DATA_W, 8, byte width of literals and output data
- WIN_DEPTH, 16, history window depth in bytes; power of two
- OFF_W, 4, width of token_offset; WIN_DEPTH-1 is the largest reachable offset
- LEN_W, 4, width of token_length (max copy length 2^LEN_W-1)
- CNT_W, 16, width of out_count

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- token_valid  input  1  token fields valid
- token_ready  output  1  decoder can accept a token
- token_offset  input  OFF_W  back distance; 1 = most recently emitted byte
- token_length  input  LEN_W  bytes to copy; 0 = literal-only token
- token_char  input  DATA_W  literal emitted after the copy
- data_out  output  DATA_W  reconstructed byte
- data_valid  output  1  data_out valid
- data_ready  input  1  sink accepts data_out
- busy  output  1  token in progress (FSM not IDLE)
- err  output  1  sticky: invalid back-reference seen
- out_count  output  CNT_W  total bytes emitted, wraps modulo 2^CNT_W

Behaviour:
- Reset (asynchronous, active-high): FSM=IDLE, wr_ptr=0, rd_ptr=0, hist_count=0, remaining=0, data_out=0, data_valid=0, busy=0, err=0, out_count=0. History RAM contents are not reset; they are don't-care because hist_count=0.
- FSM states: IDLE, COPY, LIT.
- token_ready=1 only in IDLE. A token is accepted on a rising edge with token_valid && token_ready. offset/length/char are latched on acceptance.
- Reference validity on acceptance: valid iff length==0, or 1<=offset<=hist_count.
- IDLE transitions on acceptance:
  - length==0 -> LIT.
  - Valid and length>0 -> COPY, with rd_ptr = wr_ptr - offset (mod WIN_DEPTH) and remaining = length.
  - Invalid -> err<=1, copy skipped, -> LIT. The literal is still emitted.
- COPY:
  - data_out = hist[rd_ptr], data_valid=1.
  - On data_valid && data_ready: write data_out to hist[wr_ptr], advance wr_ptr and rd_ptr (mod WIN_DEPTH), remaining--, out_count++, hist_count = min(hist_count+1, WIN_DEPTH).
  - When remaining reaches 0 -> LIT.
- LIT:
  - data_out = latched char, data_valid=1.
  - On handshake: write the char to history, update pointers and counts, -> IDLE.
- Latency: token accepted at edge N; first output byte valid in the cycle after edge N. One byte per cycle while data_ready=1. A token of length L occupies L+1 output beats. The next token is accepted on the edge after the LIT handshake, so there is one bubble cycle in IDLE.
- Overlapping copy (offset < length) must work. A history write at a handshake edge is visible to the read in the next cycle, so offset=1, length=n replicates the last byte n times.
- Backpressure: while data_valid && !data_ready, data_out, pointers, remaining and state hold. No byte is skipped or duplicated.
- Window wrap: wr_ptr and rd_ptr wrap modulo WIN_DEPTH. hist_count saturates at WIN_DEPTH.
- err is sticky until rst. It never blocks operation.
- Reset mid-token: the token is abandoned immediately and data_valid drops asynchronously. The history is treated as empty afterwards.
- busy = (state != IDLE).

Test Plan:
- Literals: after rst, tokens (0,0,'A'),(0,0,'B'),(0,0,'C') with data_ready=1 -> output A,B,C; out_count=3; err=0.
- Back-reference: continue with (3,3,'D') -> output A,B,C,D; cumulative stream ABCABCD; out_count=7; first byte one cycle after acceptance.
- Overlap plus backpressure: after rst, (0,0,'A') then (1,4,'B'), with data_ready held low 3 cycles after the second copy beat -> output A,A,A,A,A,B; data_out stable at 'A' while stalled; out_count=6.
- Invalid reference: after rst, (2,3,'X') -> err=1, only 'X' emitted, out_count=1. A subsequent (0,0,'Y') -> 'Y' emitted, err stays 1.
- Window wrap: literals 0x00..0x13 (20 bytes), then (15,2,'Z') -> 0x05,0x06,'Z'; hist_count=16.
- Reset mid-copy: assert rst during the 2nd beat of a length-5 copy -> data_valid=0, busy=0, out_count=0 immediately. A following (1,1,'Q') sets err=1 and emits only 'Q'.
